// File: rtl/spike_pkg.sv
// Shared constants and types for the spike decoder and related neuron blocks.
// Q8_SHIFT is the fixed-point scale used by all /256 arithmetic.
package spike_pkg;

   localparam logic [15:0] NO_SPIKE = 16'hFFFF;
   localparam int unsigned Q8_SHIFT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

endpackage

// File: rtl/spike_decoder_if.sv
// Spike-in / result-out signal bundle for spike_decoder.
// The master side drives the spike train and consumes results; the slave side is the decoder.
interface spike_decoder_if;

   logic        spike;
   logic        enable;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] out_count;
   logic [15:0] out_first;
   logic [15:0] out_trace;
   logic        overrun;

   modport master (
      output spike, enable, out_ready,
      input  out_valid, out_count, out_first, out_trace, overrun
   );

   modport slave (
      input  spike, enable, out_ready,
      output out_valid, out_count, out_first, out_trace, overrun
   );

endinterface

// File: rtl/spike_trace.sv
// Decaying synaptic trace: trace' = trace*ALPHA/256 + (spike ? WEIGHT : 0), saturating at 16 bits.
// One-cycle latency from spike to trace; no backpressure.
module spike_trace
   import spike_pkg::*;
#(
   parameter int unsigned ALPHA  = 224,
   parameter int unsigned WEIGHT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spike,
   output logic [15:0] trace
);

   logic [15:0] trace_q, trace_d;
   logic [23:0] decay;
   logic [23:0] sum;

   // 24 bits holds trace*ALPHA (ALPHA < 256) and the decayed value plus a full 16-bit weight.
   always_comb begin
      decay   = (24'(trace_q) * 24'(ALPHA)) >> Q8_SHIFT;
      sum     = decay + (spike ? 24'(WEIGHT) : 24'd0);
      trace_d = (sum > 24'h00FFFF) ? 16'hFFFF : sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trace_q <= 16'd0;
      end else begin
         trace_q <= trace_d;
      end
   end

   assign trace = trace_q;

endmodule

// File: rtl/spike_decoder.sv
// Windowed spike count / first-spike latency decoder with a single-entry valid/ready result slot.
// Result appears on the edge sampling the last window cycle; a full, unaccepted slot drops the result and sets sticky overrun.
module spike_decoder
   import spike_pkg::*;
#(
   parameter int unsigned WINDOW = 64,
   parameter int unsigned ALPHA  = 224,
   parameter int unsigned WEIGHT = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   spike_decoder_if.slave  io
);

   localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

   state_t      state_q, state_d;
   logic [15:0] win_cnt_q, win_cnt_d;
   logic [15:0] spk_cnt_q, spk_cnt_d;
   logic [15:0] first_q, first_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_count_q, out_count_d;
   logic [15:0] out_first_q, out_first_d;
   logic        overrun_q, overrun_d;

   logic [15:0] cnt_nxt;
   logic [15:0] first_nxt;
   logic        win_end;
   logic        load;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (io.enable)  state_d = COUNT;
         COUNT:   if (!io.enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters are always zero in IDLE, so the entry edge shares the COUNT sampling path as cycle 0.
   always_comb begin
      win_cnt_d = win_cnt_q;
      spk_cnt_d = spk_cnt_q;
      first_d   = first_q;
      win_end   = 1'b0;
      cnt_nxt   = spk_cnt_q + 16'(io.spike);
      first_nxt = (io.spike && (first_q == NO_SPIKE)) ? win_cnt_q : first_q;

      if (io.enable) begin
         if (win_cnt_q == WIN_LAST) begin
            win_end   = 1'b1;
            win_cnt_d = 16'd0;
            spk_cnt_d = 16'd0;
            first_d   = NO_SPIKE;
         end else begin
            win_cnt_d = win_cnt_q + 16'd1;
            spk_cnt_d = cnt_nxt;
            first_d   = first_nxt;
         end
      end else begin
         win_cnt_d = 16'd0;
         spk_cnt_d = 16'd0;
         first_d   = NO_SPIKE;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      out_first_d = out_first_q;
      overrun_d   = overrun_q;
      load        = win_end && (!out_valid_q || io.out_ready);

      if (load) begin
         out_valid_d = 1'b1;
         out_count_d = cnt_nxt;
         out_first_d = first_nxt;
      end else if (out_valid_q && io.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (win_end && !load) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         win_cnt_q   <= 16'd0;
         spk_cnt_q   <= 16'd0;
         first_q     <= NO_SPIKE;
         out_valid_q <= 1'b0;
         out_count_q <= 16'd0;
         out_first_q <= NO_SPIKE;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_d;
         spk_cnt_q   <= spk_cnt_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         out_first_q <= out_first_d;
         overrun_q   <= overrun_d;
      end
   end

   spike_trace #(
      .ALPHA  (ALPHA),
      .WEIGHT (WEIGHT)
   ) u_trace (
      .clk   (clk),
      .rst_n (rst_n),
      .spike (io.spike),
      .trace (io.out_trace)
   );

   assign io.out_valid = out_valid_q;
   assign io.out_count = out_count_q;
   assign io.out_first = out_first_q;
   assign io.overrun   = overrun_q;

endmodule
